// File: rtl/br_resolve_pred.sv
// ---------------------------------------------------------------------------
// br_resolve_pred
// Branch resolution and prediction unit. Resolves conditional branches and
// JAL in EX using the branch comparator, trains a bimodal BHT with an
// attached BTB, predicts taken/target for the fetch PC, and issues a
// registered one-cycle flush with the corrected next PC on a mispredict.
//
// Ports:
//   clk, rst_n            core clock (rising edge), async active-low reset
//   i_if_pc               fetch PC to predict
//   o_pred_taken          combinational prediction for i_if_pc
//   o_pred_target         predicted target, 0 when not predicted taken
//   i_ex_valid            EX stage holds a valid instruction
//   i_ex_is_br            EX instruction is B-type
//   i_ex_is_jmp           EX instruction is JAL (priority over i_ex_is_br)
//   i_ex_funct3           B-type funct3
//   i_ex_pc               PC of the EX instruction
//   i_ex_target           computed branch/jump target
//   i_ex_pred_taken       prediction carried down the pipe
//   i_ex_pred_target      predicted target carried down the pipe
//   o_br_un               comparator select, 1 = signed, 0 = unsigned
//   i_br_less/i_br_equal  comparator results
//   o_flush               registered mispredict pulse
//   o_redirect_pc         registered correct next PC, valid while o_flush=1
//   o_stat_br             saturating count of resolved branches and jumps
//   o_stat_miss           saturating count of mispredicts
// ---------------------------------------------------------------------------
module br_resolve_pred #(
  parameter int IDX_W = 6,
  parameter int TAG_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_if_pc,
  output logic        o_pred_taken,
  output logic [31:0] o_pred_target,
  input  logic        i_ex_valid,
  input  logic        i_ex_is_br,
  input  logic        i_ex_is_jmp,
  input  logic [2:0]  i_ex_funct3,
  input  logic [31:0] i_ex_pc,
  input  logic [31:0] i_ex_target,
  input  logic        i_ex_pred_taken,
  input  logic [31:0] i_ex_pred_target,
  output logic        o_br_un,
  input  logic        i_br_less,
  input  logic        i_br_equal,
  output logic        o_flush,
  output logic [31:0] o_redirect_pc,
  output logic [31:0] o_stat_br,
  output logic [31:0] o_stat_miss
);

  localparam int DEPTH = 1 << IDX_W;

  // Prediction tables
  logic             r_valid  [DEPTH];
  logic [TAG_W-1:0] r_tag    [DEPTH];
  logic             r_jmp    [DEPTH];
  logic [1:0]       r_ctr    [DEPTH];
  logic [31:0]      r_target [DEPTH];

  logic        r_flush;
  logic [31:0] r_redirect_pc;
  logic [31:0] r_stat_br;
  logic [31:0] r_stat_miss;

  logic [IDX_W-1:0] w_if_idx;
  logic [TAG_W-1:0] w_if_tag;
  logic             w_if_hit;
  logic [IDX_W-1:0] w_ex_idx;
  logic [TAG_W-1:0] w_ex_tag;
  logic             w_ex_hit;
  logic             w_cond;
  logic             w_br_legal;
  logic             w_taken;
  logic             w_resolve;
  logic             w_mispred;
  logic [31:0]      w_next_pc;

  // Fetch-side lookup reads the registered tables, so a same-cycle update
  // to the same index is only visible from the following cycle.
  assign w_if_idx      = i_if_pc[IDX_W+1:2];
  assign w_if_tag      = i_if_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign w_if_hit      = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
  assign o_pred_taken  = w_if_hit && (r_jmp[w_if_idx] || r_ctr[w_if_idx][1]);
  assign o_pred_target = o_pred_taken ? r_target[w_if_idx] : 32'd0;

  assign w_ex_idx = i_ex_pc[IDX_W+1:2];
  assign w_ex_tag = i_ex_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign w_ex_hit = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);

  // funct3[1] distinguishes the unsigned compares (BLTU/BGEU)
  assign o_br_un = ~i_ex_funct3[1];

  // Branch condition decode; funct3 010/011 are not branches
  always_comb begin
    w_cond     = 1'b0;
    w_br_legal = 1'b1;
    case (i_ex_funct3)
      3'b000:         w_cond = i_br_equal;
      3'b001:         w_cond = ~i_br_equal;
      3'b100, 3'b110: w_cond = i_br_less;
      3'b101, 3'b111: w_cond = ~i_br_less;
      default: begin
        w_cond     = 1'b0;
        w_br_legal = 1'b0;
      end
    endcase
  end

  // JAL wins over B-type and ignores funct3
  assign w_taken   = i_ex_is_jmp | (i_ex_is_br & w_br_legal & w_cond);
  assign w_resolve = i_ex_valid & (i_ex_is_jmp | (i_ex_is_br & w_br_legal));
  assign w_mispred = w_resolve &
                     ((w_taken != i_ex_pred_taken) |
                      (w_taken & (i_ex_target != i_ex_pred_target)));
  assign w_next_pc = w_taken ? i_ex_target : (i_ex_pc + 32'd4);

  // BHT/BTB training
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_jmp[i]    <= 1'b0;
        r_ctr[i]    <= 2'b01;
        r_target[i] <= 32'd0;
      end
    end else if (w_resolve) begin
      if (w_taken) begin
        if (w_ex_hit) begin
          if (r_ctr[w_ex_idx] != 2'b11) r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] + 2'd1;
          r_target[w_ex_idx] <= i_ex_target;
        end else begin
          // Allocate over whatever aliased entry lives here
          r_valid[w_ex_idx]  <= 1'b1;
          r_tag[w_ex_idx]    <= w_ex_tag;
          r_target[w_ex_idx] <= i_ex_target;
          r_jmp[w_ex_idx]    <= i_ex_is_jmp;
          r_ctr[w_ex_idx]    <= 2'b10;
        end
      end else if (w_ex_hit && (r_ctr[w_ex_idx] != 2'b00)) begin
        r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] - 2'd1;
      end
    end
  end

  // Redirect pulse and statistics; redirect_pc holds between pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flush       <= 1'b0;
      r_redirect_pc <= 32'd0;
      r_stat_br     <= 32'd0;
      r_stat_miss   <= 32'd0;
    end else begin
      r_flush <= w_mispred;
      if (w_mispred) r_redirect_pc <= w_next_pc;
      if (w_resolve && (r_stat_br != 32'hFFFF_FFFF)) r_stat_br <= r_stat_br + 32'd1;
      if (w_mispred && (r_stat_miss != 32'hFFFF_FFFF)) r_stat_miss <= r_stat_miss + 32'd1;
    end
  end

  assign o_flush       = r_flush;
  assign o_redirect_pc = r_redirect_pc;
  assign o_stat_br     = r_stat_br;
  assign o_stat_miss   = r_stat_miss;

endmodule

// File: tb/tb_br_resolve_pred.sv
// ---------------------------------------------------------------------------
// tb_br_resolve_pred
// Directed and randomized stimulus for br_resolve_pred, checked against a
// table-of-entries reference model held in the bench.
// ---------------------------------------------------------------------------
module tb_br_resolve_pred;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid, ex_is_br, ex_is_jmp;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_pc, ex_target, ex_pred_target;
  logic        ex_pred_taken;
  logic        br_un, br_less, br_equal;
  logic        flush;
  logic [31:0] redirect_pc, stat_br, stat_miss;

  int checks = 0;
  int errors = 0;

  // Reference model: one record per index
  bit          mValid [64];
  int          mTag   [64];
  bit          mJmp   [64];
  int          mCtr   [64];
  logic [31:0] mTgt   [64];
  logic [31:0] mStatBr, mStatMiss, mRedirect;
  bit          mFlush;

  always #5 clk = ~clk;

  br_resolve_pred dut (
    .clk(clk), .rst_n(rst_n),
    .i_if_pc(if_pc), .o_pred_taken(pred_taken), .o_pred_target(pred_target),
    .i_ex_valid(ex_valid), .i_ex_is_br(ex_is_br), .i_ex_is_jmp(ex_is_jmp),
    .i_ex_funct3(ex_funct3), .i_ex_pc(ex_pc), .i_ex_target(ex_target),
    .i_ex_pred_taken(ex_pred_taken), .i_ex_pred_target(ex_pred_target),
    .o_br_un(br_un), .i_br_less(br_less), .i_br_equal(br_equal),
    .o_flush(flush), .o_redirect_pc(redirect_pc),
    .o_stat_br(stat_br), .o_stat_miss(stat_miss)
  );

  task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 64; i++) begin
      mValid[i] = 0; mTag[i] = 0; mJmp[i] = 0; mCtr[i] = 1; mTgt[i] = 0;
    end
    mStatBr = 0; mStatMiss = 0; mRedirect = 0; mFlush = 0;
  endtask

  function automatic int idxOf(input logic [31:0] pc);
    return int'((pc / 4) % 64);
  endfunction

  function automatic int tagOf(input logic [31:0] pc);
    return int'((pc / 256) % 256);
  endfunction

  task automatic modelPredict(input logic [31:0] pc, output bit t, output logic [31:0] tg);
    int i = idxOf(pc);
    bit hit = mValid[i] && (mTag[i] == tagOf(pc));
    t  = hit && (mJmp[i] || mCtr[i] >= 2);
    tg = t ? mTgt[i] : 32'd0;
  endtask

  task automatic modelResolve(input bit v, input bit isBr, input bit isJmp, input int f3,
                              input logic [31:0] pc, input logic [31:0] tgt,
                              input bit predT, input logic [31:0] predTgt,
                              input bit less, input bit eq);
    bit legal, taken, hit, mis;
    int i;
    legal = isJmp || (f3 != 2 && f3 != 3);
    mFlush = 0;
    if (!(v && (isBr || isJmp) && legal)) return;
    if (isJmp) taken = 1;
    else begin
      case (f3)
        0: taken = eq;
        1: taken = !eq;
        4, 6: taken = less;
        default: taken = !less;
      endcase
    end
    if (mStatBr != 32'hFFFFFFFF) mStatBr++;
    mis = (taken != predT) || (taken && tgt != predTgt);
    if (mis) begin
      mFlush = 1;
      mRedirect = taken ? tgt : pc + 32'd4;
      if (mStatMiss != 32'hFFFFFFFF) mStatMiss++;
    end
    i = idxOf(pc);
    hit = mValid[i] && (mTag[i] == tagOf(pc));
    if (taken && hit) begin
      mCtr[i] = (mCtr[i] < 3) ? mCtr[i] + 1 : 3;
      mTgt[i] = tgt;
    end else if (taken) begin
      mValid[i] = 1; mTag[i] = tagOf(pc); mTgt[i] = tgt; mJmp[i] = isJmp; mCtr[i] = 2;
    end else if (hit) begin
      mCtr[i] = (mCtr[i] > 0) ? mCtr[i] - 1 : 0;
    end
  endtask

  // One EX cycle: drive, check combinational outputs, then registered ones
  task automatic applyStimulus(input bit v, input bit isBr, input bit isJmp, input int f3,
                               input logic [31:0] pc, input logic [31:0] tgt,
                               input bit predT, input logic [31:0] predTgt,
                               input bit less, input bit eq, input logic [31:0] ifpc);
    bit t;
    logic [31:0] tg;
    ex_valid = v; ex_is_br = isBr; ex_is_jmp = isJmp; ex_funct3 = 3'(f3);
    ex_pc = pc; ex_target = tgt; ex_pred_taken = predT; ex_pred_target = predTgt;
    br_less = less; br_equal = eq; if_pc = ifpc;
    #2;
    modelPredict(ifpc, t, tg);
    checkOutput("pred_taken", 32'(pred_taken), 32'(t));
    checkOutput("pred_target", pred_target, tg);
    checkOutput("br_un", 32'(br_un), 32'((f3 == 4 || f3 == 5 || f3 == 0 || f3 == 1) ? 1 : 0));
    modelResolve(v, isBr, isJmp, f3, pc, tgt, predT, predTgt, less, eq);
    @(posedge clk); #1;
    checkOutput("flush", 32'(flush), 32'(mFlush));
    if (mFlush) checkOutput("redirect_pc", redirect_pc, mRedirect);
    checkOutput("stat_br", stat_br, mStatBr);
    checkOutput("stat_miss", stat_miss, mStatMiss);
    ex_valid = 0;
  endtask

  // Resolve a branch using the model's own prediction as the carried one
  task automatic resolveTrained(input int f3, input logic [31:0] pc, input logic [31:0] tgt,
                                input bit less, input bit eq, input logic [31:0] ifpc);
    bit t;
    logic [31:0] tg;
    modelPredict(pc, t, tg);
    applyStimulus(1, 1, 0, f3, pc, tgt, t, tg, less, eq, ifpc);
  endtask

  initial begin
    bit t, isBr, isJmp;
    logic [31:0] tg, pc, tgt, pTgt;
    int f3;

    rst_n = 0; if_pc = 32'h100; ex_valid = 0; ex_is_br = 0; ex_is_jmp = 0;
    ex_funct3 = 0; ex_pc = 0; ex_target = 0; ex_pred_taken = 0; ex_pred_target = 0;
    br_less = 0; br_equal = 0;
    modelReset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    // Reset state
    checkOutput("rst_flush", 32'(flush), 0);
    checkOutput("rst_redirect", redirect_pc, 0);
    checkOutput("rst_stat_br", stat_br, 0);
    checkOutput("rst_stat_miss", stat_miss, 0);
    checkOutput("rst_pred", 32'(pred_taken), 0);

    // BEQ taken, predicted not taken
    applyStimulus(1, 1, 0, 0, 32'h100, 32'h80, 0, 0, 0, 1, 32'h100);
    checkOutput("beq_flush", 32'(flush), 1);
    checkOutput("beq_redirect", redirect_pc, 32'h80);
    checkOutput("beq_stats", {stat_br[15:0], stat_miss[15:0]}, 32'h0001_0001);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h100);
    checkOutput("beq_pred", 32'(pred_taken), 1);
    checkOutput("beq_pred_tgt", pred_target, 32'h80);

    // Comparator select
    applyStimulus(0, 1, 0, 6, 0, 0, 0, 0, 0, 0, 0);
    ex_funct3 = 3'b110; #1 checkOutput("bltu_br_un", 32'(br_un), 0);
    ex_funct3 = 3'b100; #1 checkOutput("blt_br_un", 32'(br_un), 1);

    // BGE with less=1 predicted taken: falls through
    applyStimulus(1, 1, 0, 5, 32'h100, 32'h80, 1, 32'h80, 1, 0, 32'h0);
    checkOutput("bge_flush", 32'(flush), 1);
    checkOutput("bge_redirect", redirect_pc, 32'h104);

    // Counter saturation at 0x200
    repeat (4) resolveTrained(0, 32'h200, 32'h240, 0, 1, 32'h200);
    resolveTrained(0, 32'h200, 32'h240, 0, 0, 32'h200);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h200);
    checkOutput("sat_pred_1", 32'(pred_taken), 1);
    resolveTrained(0, 32'h200, 32'h240, 0, 0, 32'h200);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h200);
    checkOutput("sat_pred_0", 32'(pred_taken), 0);

    // JAL with wrong predicted target, then an illegal funct3
    applyStimulus(1, 0, 1, 2, 32'h300, 32'h1000, 1, 32'h2000, 0, 0, 32'h300);
    checkOutput("jal_flush", 32'(flush), 1);
    checkOutput("jal_redirect", redirect_pc, 32'h1000);
    tg = stat_br;
    applyStimulus(1, 1, 0, 2, 32'h400, 32'h500, 0, 0, 1, 1, 32'h400);
    checkOutput("illegal_flush", 32'(flush), 0);
    checkOutput("illegal_stat", stat_br, tg);

    // Aliasing eviction
    applyStimulus(1, 1, 0, 0, 32'h100, 32'h80, 0, 0, 0, 1, 32'h100);
    applyStimulus(1, 1, 0, 0, 32'h200, 32'h90, 0, 0, 0, 1, 32'h100);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h100);
    checkOutput("alias_pred", 32'(pred_taken), 0);

    // Reset during a mispredicting resolve
    ex_valid = 1; ex_is_br = 1; ex_is_jmp = 0; ex_funct3 = 0; ex_pc = 32'h200;
    ex_target = 32'h90; ex_pred_taken = 0; br_equal = 1; if_pc = 32'h200;
    #2 rst_n = 0;
    #1 checkOutput("rst_async_pred", 32'(pred_taken), 0);
    @(posedge clk); #1;
    ex_valid = 0;
    modelReset();
    checkOutput("rst_mid_flush", 32'(flush), 0);
    checkOutput("rst_mid_stats", stat_br | stat_miss, 0);
    rst_n = 1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h200);

    // Wrap of fall-through PC
    applyStimulus(1, 1, 0, 1, 32'hFFFFFFFC, 32'h40, 1, 32'h40, 0, 1, 32'h0);
    checkOutput("wrap_flush", 32'(flush), 1);
    checkOutput("wrap_redirect", redirect_pc, 32'h0);

    // Randomized traffic over a small aliasing PC pool
    for (int n = 0; n < 400; n++) begin
      pc  = (32'($urandom_range(0, 15)) << 2) + (32'($urandom_range(0, 3)) << 8);
      tgt = 32'($urandom_range(0, 7)) << 4;
      f3  = int'($urandom_range(0, 7));
      isJmp = ($urandom_range(0, 5) == 0);
      isBr  = ($urandom_range(0, 4) != 0);
      modelPredict(pc, t, tg);
      if ($urandom_range(0, 9) < 7) pTgt = tg;
      else begin
        t = 1'($urandom);
        pTgt = t ? 32'($urandom_range(0, 7)) << 4 : 32'd0;
      end
      applyStimulus(($urandom_range(0, 5) != 0), isBr, isJmp, f3, pc, tgt, t, pTgt,
                    1'($urandom), 1'($urandom),
                    (32'($urandom_range(0, 15)) << 2) + (32'($urandom_range(0, 3)) << 8));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/br_resolve_pred.md
Name: br_resolve_pred

Overview:
- Branch resolution and prediction unit for the pipelined core.
- Sits at the consumer end of the branch comparator. It drives the comparator's br_un select and consumes br_less/br_equal.
- It resolves conditional branches and JAL in EX, trains a bimodal branch history table (BHT) plus branch target buffer (BTB), and predicts for IF.
- It issues a registered redirect/flush when a prediction was wrong.

Parameters:
- IDX_W, 6, BHT/BTB index width; table depth 2**IDX_W entries.
- TAG_W, 8, BTB tag width in PC bits.

Ports:
- clk  input  1  core clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- if_pc  input  32  fetch PC to predict
- pred_taken  output  1  combinational prediction for if_pc
- pred_target  output  32  predicted target; 0 when pred_taken=0
- ex_valid  input  1  EX stage holds a valid instruction
- ex_is_br  input  1  EX instruction is B-type
- ex_is_jmp  input  1  EX instruction is JAL
- ex_funct3  input  3  B-type funct3
- ex_pc  input  32  PC of the EX instruction
- ex_target  input  32  computed branch/jump target
- ex_pred_taken  input  1  prediction carried down the pipe
- ex_pred_target  input  32  predicted target carried down the pipe
- br_un  output  1  to comparator; 1 = signed, 0 = unsigned
- br_less  input  1  from comparator
- br_equal  input  1  from comparator
- flush  output  1  registered mispredict pulse
- redirect_pc  output  32  registered correct next PC, valid while flush=1
- stat_br  output  32  count of resolved branches and jumps
- stat_miss  output  32  count of mispredicts

Behaviour:
- br_un = ~ex_funct3[1], combinational. Signed for BLT/BGE, unsigned for BLTU/BGEU; don't-care for BEQ/BNE.
- Outcome (combinational, named "taken"):
  - 000 → br_equal
  - 001 → ~br_equal
  - 100 → br_less
  - 101 → ~br_less
  - 110 → br_less
  - 111 → ~br_less
  - 010/011 are illegal: taken=0, resolve is ignored entirely (no update, no flush, no stats).
- A resolve event is ex_valid & (ex_is_br | ex_is_jmp) & legal.
  - ex_is_jmp has priority over ex_is_br. A JAL is always taken and funct3 is ignored.
  - JALR is driven with both flags low and is never handled.
- Index and tag: idx = pc[IDX_W+1:2], tag = pc[IDX_W+TAG_W+1:IDX_W+2].
- Each entry holds: valid, tag, jmp flag, 2-bit counter, 32-bit target.
- Prediction (combinational): hit = valid[idx] & tag match; pred_taken = hit & (jmp | ctr[1]); pred_target = ex. the entry target when pred_taken=1, else 0.
- Table update at the rising edge after a resolve event:
  - Taken with hit: ctr saturating increment (max 11), target rewritten.
  - Taken with miss: allocate the entry (valid=1, tag, target, jmp=ex_is_jmp, ctr=10), overwriting any victim.
  - Not taken with hit: ctr saturating decrement (min 00).
  - Not taken with miss: no change.
- Read-during-write: an IF lookup in the same cycle as an update to that index sees the old contents. The new contents are visible from the next cycle.
- Mispredict = resolve event & (taken != ex_pred_taken | (taken & ex_target != ex_pred_target)).
- flush/redirect_pc are registered, 1-cycle latency. flush is high for exactly one cycle after a mispredicting EX cycle.
  - redirect_pc = taken ? ex_target : ex_pc + 4, with 32-bit wrap (0xFFFFFFFC + 4 = 0).
  - Back-to-back mispredicts produce back-to-back flush pulses.
- Stats: stat_br increments on each resolve event; stat_miss increments on each mispredict. Both saturate at 0xFFFFFFFF.
- Reset (asynchronous, any time, including mid-resolve):
  - All valid bits cleared, all ctr = 01, targets/tags = 0.
  - flush=0, redirect_pc=0, stat_br=0, stat_miss=0.
  - pred_taken=0 and pred_target=0 immediately.
  - A resolve event in progress at reset is discarded.

Test Plan:
- Reset, then BEQ at ex_pc=0x100, target 0x80, br_equal=1, ex_pred_taken=0 → next cycle flush=1, redirect_pc=0x80, stat_br=1, stat_miss=1. Following cycle if_pc=0x100 → pred_taken=1, pred_target=0x80.
- BLTU with ex_funct3=110 → br_un=0. BLT with 100 → br_un=1. BGE at 0x100, br_less=1, predicted taken → flush, redirect_pc=0x104.
- Counter saturation: train 0x200 taken 4 times, then not taken once → pred_taken stays 1 (ctr 11→10). A second not-taken → pred_taken=0.
- JAL at 0x300→0x1000 with ex_pred_taken=1 but ex_pred_target=0x2000 → flush, redirect_pc=0x1000. funct3=010 with ex_is_br=1 only → no flush, no stat change.
- Alias: 0x100 and 0x100 + 2**(IDX_W+2) both taken → second one evicts the first, and if_pc=0x100 then misses (pred_taken=0).
- Assert rst_n low in the same cycle as a mispredicting resolve → flush stays 0, stats 0, table cleared. ex_pc=0xFFFFFFFC, not taken, predicted taken → redirect_pc=0x00000000.
